// File: rtl/pc_redirect_unit.sv
// Fetch-PC register and control-redirect stage: selects branch/jump targets, issues
// pipeline flushes, traps misaligned targets and counts accepted redirects.
module pc_redirect_unit #(
  parameter int unsigned          XLEN          = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR  = 32'h0000_0000,
  parameter logic [XLEN-1:0]      TRAP_VECTOR   = 32'h0000_0100,
  parameter int unsigned          SHADOW_CYCLES = 2,
  parameter int unsigned          CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             Stall,
  input  logic             En,
  input  logic             Branch_taken,
  input  logic             Jump,
  input  logic             Jalr_sel,
  input  logic [XLEN-1:0]  EX_PC,
  input  logic [XLEN-1:0]  Imm,
  input  logic [XLEN-1:0]  Rs1,
  input  logic             Exc_ack,
  input  logic             Clr_cnt,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PC_plus4,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Misaligned_exc,
  output logic [XLEN-1:0]  Exc_addr,
  output logic [CNT_W-1:0] Redirect_cnt
);

  localparam int unsigned ShW = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StRun, StShadow, StTrap} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  exc_addr_q, exc_addr_d;
  logic [ShW-1:0]   shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;
  logic             req;
  logic             flush;
  logic             cnt_inc;

  assign jalr_sum = Rs1 + Imm;
  assign target   = Jalr_sel ? {jalr_sum[XLEN-1:1], 1'b0} : (EX_PC + Imm);
  assign req      = (En & Branch_taken) | Jump;
  assign PC_plus4 = pc_q + XLEN'(4);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    exc_addr_d = exc_addr_q;
    shadow_d   = shadow_q;
    cnt_inc    = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (req) begin
          // Redirects and traps take effect regardless of Stall.
          flush = 1'b1;
          if (target[1]) begin
            pc_d       = TRAP_VECTOR;
            exc_addr_d = target;
            state_d    = StTrap;
          end else begin
            pc_d    = target;
            cnt_inc = 1'b1;
            if (SHADOW_CYCLES != 0) begin
              shadow_d = ShW'(SHADOW_CYCLES);
              state_d  = StShadow;
            end
          end
        end else if (!Stall) begin
          pc_d = PC_plus4;
        end
      end
      StShadow: begin
        // Requests here come from slots already squashed by the previous redirect.
        if (!Stall) begin
          pc_d     = PC_plus4;
          shadow_d = shadow_q - ShW'(1);
          if (shadow_q <= ShW'(1)) begin
            state_d = StRun;
          end
        end
      end
      StTrap: begin
        flush = 1'b1;
        if (Exc_ack) begin
          pc_d    = TRAP_VECTOR + XLEN'(4);
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Clr_cnt) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_VECTOR;
      exc_addr_q <= '0;
      shadow_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      exc_addr_q <= exc_addr_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
    end
  end

  assign PC             = pc_q;
  assign Flush_IF_ID    = flush;
  assign Flush_ID_EX    = flush;
  assign Misaligned_exc = (state_q == StTrap);
  assign Exc_addr       = exc_addr_q;
  assign Redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scenario-driven bench for pc_redirect_unit; a second instance without a shadow window
// and with a narrow counter exercises counter saturation.
module tb_pc_redirect_unit;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        Stall, En, Branch_taken, Jump, Jalr_sel, Exc_ack, Clr_cnt;
  logic [31:0] EX_PC, Imm, Rs1;

  logic [31:0] pc_a, pc4_a, exc_addr_a;
  logic        fl_ifid_a, fl_idex_a, exc_a;
  logic [15:0] cnt_a;

  logic [31:0] pc_b, pc4_b, exc_addr_b;
  logic        fl_ifid_b, fl_idex_b, exc_b;
  logic [7:0]  cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  pc_redirect_unit dut_a (
    .CLK(CLK), .rst_n(rst_n), .Stall(Stall), .En(En), .Branch_taken(Branch_taken),
    .Jump(Jump), .Jalr_sel(Jalr_sel), .EX_PC(EX_PC), .Imm(Imm), .Rs1(Rs1),
    .Exc_ack(Exc_ack), .Clr_cnt(Clr_cnt), .PC(pc_a), .PC_plus4(pc4_a),
    .Flush_IF_ID(fl_ifid_a), .Flush_ID_EX(fl_idex_a), .Misaligned_exc(exc_a),
    .Exc_addr(exc_addr_a), .Redirect_cnt(cnt_a)
  );

  pc_redirect_unit #(.SHADOW_CYCLES(0), .CNT_W(8)) dut_b (
    .CLK(CLK), .rst_n(rst_n), .Stall(Stall), .En(En), .Branch_taken(Branch_taken),
    .Jump(Jump), .Jalr_sel(Jalr_sel), .EX_PC(EX_PC), .Imm(Imm), .Rs1(Rs1),
    .Exc_ack(Exc_ack), .Clr_cnt(Clr_cnt), .PC(pc_b), .PC_plus4(pc4_b),
    .Flush_IF_ID(fl_ifid_b), .Flush_ID_EX(fl_idex_b), .Misaligned_exc(exc_b),
    .Exc_addr(exc_addr_b), .Redirect_cnt(cnt_b)
  );

  task automatic idle_inputs();
    Stall = 0; En = 0; Branch_taken = 0; Jump = 0; Jalr_sel = 0;
    Exc_ack = 0; Clr_cnt = 0; EX_PC = '0; Imm = '0; Rs1 = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    rst_n = 0;
    #3;
    n_checks++;
    if ({pc_a, exc_addr_a, cnt_a, exc_a, fl_ifid_a, fl_idex_a} !== {32'h0, 32'h0, 16'h0, 3'b000})
      $display("FAIL reset_state: got pc=%h ea=%h cnt=%h exc=%b fl=%b%b want all zero",
               pc_a, exc_addr_a, cnt_a, exc_a, fl_ifid_a, fl_idex_a);
    else n_pass++;
    @(negedge CLK);
    rst_n = 1;
    #1;
    for (int i = 0; i < 4; i++) sb.push_back('{pc: 32'(i * 4), cnt: 16'h0});
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      n_checks++;
      if (pc_a !== e.pc || cnt_a !== e.cnt || fl_ifid_a !== 1'b0 || fl_idex_a !== 1'b0)
        $display("FAIL reset_run[%0d]: got pc=%h cnt=%h fl=%b%b want pc=%h cnt=%h fl=00",
                 i, pc_a, cnt_a, fl_ifid_a, fl_idex_a, e.pc, e.cnt);
      else n_pass++;
      if (i < 3) tick();
    end
    tick();
  endtask

  task automatic test_branch_shadow();
    exp_t e;
    En = 1; Branch_taken = 1; EX_PC = 32'h40; Imm = 32'hFFFF_FFF0;
    #1;
    n_checks++;
    if (fl_ifid_a !== 1'b1 || fl_idex_a !== 1'b1)
      $display("FAIL branch_flush: got %b%b want 11", fl_ifid_a, fl_idex_a);
    else n_pass++;
    sb.push_back('{pc: 32'h30, cnt: 16'd1});
    sb.push_back('{pc: 32'h34, cnt: 16'd1});
    sb.push_back('{pc: 32'h38, cnt: 16'd1});
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      e = sb.pop_front();
      n_checks++;
      if (pc_a !== e.pc || cnt_a !== e.cnt)
        $display("FAIL branch_pc[%0d]: got pc=%h cnt=%h want pc=%h cnt=%h",
                 i, pc_a, cnt_a, e.pc, e.cnt);
      else n_pass++;
      if (i < 2) begin
        n_checks++;
        if (fl_ifid_a !== 1'b0)
          $display("FAIL shadow_flush[%0d]: got %b want 0", i, fl_ifid_a);
        else n_pass++;
      end
    end
    // Window has expired: the still-asserted request is live again.
    n_checks++;
    if (fl_ifid_a !== 1'b1) $display("FAIL shadow_expire: got %b want 1", fl_ifid_a);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_jalr_stall_shadow();
    exp_t e;
    Jump = 1; Jalr_sel = 1; Rs1 = 32'h1001; Imm = 32'h4; EX_PC = 32'h7000; Stall = 1;
    tick();
    n_checks++;
    if (pc_a !== 32'h1004 || cnt_a !== 16'd2)
      $display("FAIL jalr_stall: got pc=%h cnt=%h want pc=00001004 cnt=0002", pc_a, cnt_a);
    else n_pass++;
    for (int i = 0; i < 3; i++) sb.push_back('{pc: 32'h1004, cnt: 16'd2});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (pc_a !== e.pc || cnt_a !== e.cnt || fl_ifid_a !== 1'b0)
        $display("FAIL shadow_stall[%0d]: got pc=%h cnt=%h fl=%b want pc=%h cnt=%h fl=0",
                 i, pc_a, cnt_a, fl_ifid_a, e.pc, e.cnt);
      else n_pass++;
    end
    Stall = 0;
    #1;
    n_checks++;
    if (fl_ifid_a !== 1'b0) $display("FAIL shadow_kept: got flush %b want 0", fl_ifid_a);
    else n_pass++;
    #1 rst_n = 0;
    #1;
    n_checks++;
    if (pc_a !== 32'h0 || cnt_a !== 16'h0)
      $display("FAIL async_reset: got pc=%h cnt=%h want 0/0", pc_a, cnt_a);
    else n_pass++;
    @(negedge CLK);
    rst_n = 1;
    idle_inputs();
    En = 1; Branch_taken = 1; EX_PC = 32'h200; Imm = 32'h8;
    #1;
    n_checks++;
    if (fl_idex_a !== 1'b1) $display("FAIL post_reset_req: got flush %b want 1", fl_idex_a);
    else n_pass++;
    tick();
    n_checks++;
    if (pc_a !== 32'h208 || cnt_a !== 16'd1)
      $display("FAIL post_reset_pc: got pc=%h cnt=%h want 00000208/0001", pc_a, cnt_a);
    else n_pass++;
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_trap();
    Jump = 1; Jalr_sel = 0; EX_PC = 32'h20; Imm = 32'h6;
    #1;
    n_checks++;
    if (fl_ifid_a !== 1'b1 || exc_a !== 1'b0)
      $display("FAIL trap_req: got fl=%b exc=%b want fl=1 exc=0", fl_ifid_a, exc_a);
    else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pc_a !== 32'h100 || exc_a !== 1'b1 || exc_addr_a !== 32'h26 ||
          fl_ifid_a !== 1'b1 || fl_idex_a !== 1'b1)
        $display("FAIL trap_hold[%0d]: got pc=%h exc=%b ea=%h fl=%b%b want 00000100/1/00000026/11",
                 i, pc_a, exc_a, exc_addr_a, fl_ifid_a, fl_idex_a);
      else n_pass++;
      Stall = i[0]; En = 1; Branch_taken = 1; Jump = i[1]; EX_PC = 32'h500; Imm = 32'h0;
      tick();
    end
    idle_inputs();
    Exc_ack = 1;
    tick();
    n_checks++;
    if (pc_a !== 32'h104 || exc_a !== 1'b0 || cnt_a !== 16'd1)
      $display("FAIL trap_ack: got pc=%h exc=%b cnt=%h want 00000104/0/0001", pc_a, exc_a, cnt_a);
    else n_pass++;
    // Exc_ack in RUN and En=0 with Branch_taken=1 both do nothing.
    Branch_taken = 1; EX_PC = 32'h800;
    #1;
    n_checks++;
    if (fl_ifid_a !== 1'b0) $display("FAIL en_gate: got flush %b want 0", fl_ifid_a);
    else n_pass++;
    tick();
    n_checks++;
    if (pc_a !== 32'h108 || exc_a !== 1'b0)
      $display("FAIL run_ack_ignored: got pc=%h exc=%b want 00000108/0", pc_a, exc_a);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_saturation();
    exp_t e;
    Clr_cnt = 1;
    tick();
    Clr_cnt = 0;
    n_checks++;
    if (cnt_b !== 8'h0) $display("FAIL sat_clear: got %h want 00", cnt_b);
    else n_pass++;
    Jump = 1; Jalr_sel = 0; EX_PC = 32'h400; Imm = 32'h0;
    for (int i = 1; i <= 260; i++) begin
      sb.push_back('{pc: 32'h400, cnt: (i > 255) ? 16'd255 : 16'(i)});
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({8'h0, cnt_b} !== e.cnt || pc_b !== e.pc)
        $display("FAIL sat_cnt[%0d]: got cnt=%h pc=%h want cnt=%h pc=%h",
                 i, cnt_b, pc_b, e.cnt[7:0], e.pc);
      else n_pass++;
    end
    Clr_cnt = 1;
    EX_PC = 32'h480;
    tick();
    n_checks++;
    if (cnt_b !== 8'h0 || pc_b !== 32'h480)
      $display("FAIL clr_wins: got cnt=%h pc=%h want 00/00000480", cnt_b, pc_b);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_branch_shadow();
    test_jalr_stall_shadow();
    test_trap();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
